mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of 2, >=2).
REQ-002 The block SHALL have parameter BASE_ADDR, default 16'h0010, meaning first mapped memory word address.
REQ-003 The block SHALL have parameter NUM_WORDS, default 10, meaning number of mapped words starting at BASE_ADDR.
REQ-004 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port cmd_valid  input  1  command offered.
REQ-007 The block SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 The block SHALL have port cmd_op  input  1  1=write, 0=read.
REQ-009 The block SHALL have port cmd_addr  input  16  target word address.
REQ-010 The block SHALL have port cmd_wdata  input  16  write data, ignored for reads.
REQ-011 The block SHALL have port bus_valid  output  1  bus transaction strobe to memory.
REQ-012 The block SHALL have port bus_op  output  1  1=write, 0=read.
REQ-013 The block SHALL have port bus_addr  output  16  bus address.
REQ-014 The block SHALL have port bus_wr_data  output  16  bus write data.
REQ-015 The block SHALL have port bus_rd_data  input  16  memory read data, registered by memory one cycle after read strobe.
REQ-016 The block SHALL have port rsp_valid  output  1  read response available.
REQ-017 The block SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-018 The block SHALL have port rsp_data  output  16  read data returned.
REQ-019 The block SHALL have port rsp_addr  output  16  address of the read being returned.
REQ-020 The block SHALL have port rsp_err  output  1  read address outside [BASE_ADDR, BASE_ADDR+NUM_WORDS-1].
REQ-021 The block SHALL have ports wr_cnt and rd_cnt  output  16 each  completed write / accepted read response counts.
REQ-022 The block SHALL have port busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-023 Command FIFO SHALL push on cmd_valid&&cmd_ready; cmd_ready SHALL equal !full (combinational from count only).
REQ-024 Simultaneous push and pop SHALL both occur with occupancy unchanged; order SHALL be strict FIFO; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 FSM states SHALL be IDLE, ISSUE, WAIT_RD, RESP; all bus_* and rsp_* outputs SHALL be registered.
REQ-026 IDLE with FIFO non-empty: at the edge SHALL pop head, set bus_valid=1, bus_op/bus_addr/bus_wr_data from head (bus_wr_data=0 for reads), go ISSUE; IDLE with FIFO empty SHALL stay IDLE.
REQ-027 ISSUE: bus_valid SHALL be high for exactly this one cycle; at the edge bus_valid, bus_op, bus_addr, bus_wr_data SHALL return to 0; write -> wr_cnt+1, go IDLE; read -> go WAIT_RD.
REQ-028 WAIT_RD: at the edge SHALL capture rsp_data=bus_rd_data, rsp_addr=issued address, rsp_err=out-of-range flag, set rsp_valid=1, go RESP.
REQ-029 RESP: rsp_valid and rsp_data/addr/err SHALL hold stable until rsp_ready; on rsp_valid&&rsp_ready rsp_valid SHALL clear, rd_cnt+1, go IDLE.
REQ-030 Out-of-range addresses SHALL still be driven on the bus; writes to them SHALL count in wr_cnt with no response; reads SHALL return rsp_err=1 with captured data (memory returns 0).
REQ-031 Latency: read accepted into empty idle block at edge E0 SHALL show bus_valid in cycle after E0 and rsp_valid two cycles later; write throughput SHALL be one per 2 cycles.
REQ-032 wr_cnt and rd_cnt SHALL wrap from 16'hFFFF to 0.
REQ-033 Pushes while full SHALL be impossible (cmd_ready=0); cmd_valid with cmd_ready=0 SHALL have no effect.

Reset
REQ-034 reset_n=0 at an edge SHALL force state IDLE, FIFO empty, bus_valid/bus_op/bus_addr/bus_wr_data=0, rsp_valid/rsp_data/rsp_addr/rsp_err=0, wr_cnt=rd_cnt=0, busy=0.
REQ-035 Reset mid-operation SHALL discard queued commands, any in-flight bus access and any pending response without further bus_valid pulses.

Verification
REQ-036 Write 0x10<=16'hA5A5 then read 0x10 -> one bus write pulse, one read pulse, rsp_data=16'hA5A5, rsp_addr=16'h0010, rsp_err=0, wr_cnt=1, rd_cnt=1.
REQ-037 Read 0x20 -> bus read pulse at 0x20, rsp_data=0, rsp_err=1.
REQ-038 Push 5 writes back-to-back with FSM stalled in RESP (rsp_ready=0) -> cmd_ready low after 4 accepted; 5th accepted only after rsp_ready, issued in order.
REQ-039 Read issued, rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable for all 10, no further bus_valid.
REQ-040 Reset asserted in ISSUE cycle of a read with 3 queued -> next cycle all outputs 0, busy=0, no bus_valid afterward, rsp_valid never asserted.
REQ-041 Write/read all 10 addresses 0x10..0x19 with data 16'h1000+i -> each read returns 16'h1000+i, wr_cnt=10, rd_cnt=10.

Source files
------------

// File: rtl/mem_bus_master.sv
// ============================================================================
// mem_bus_master : command-FIFO fed, single-outstanding memory bus master
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_master #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0010,
  parameter int          NUM_WORDS  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        bus_valid,
  output logic        bus_op,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wr_data,
  input  logic [15:0] bus_rd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr,
  output logic        rsp_err,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic        busy
);

  localparam int            c_aw        = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_full_cnt  = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw:0] c_cnt_one   = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [16:0]   c_last_addr = {1'b0, BASE_ADDR} + 17'(NUM_WORDS) - 17'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q;
  logic [32:0]       fifo_mem_q [FIFO_DEPTH];
  logic [c_aw-1:0]   wr_ptr_q;
  logic [c_aw-1:0]   rd_ptr_q;
  logic [c_aw:0]     count_q;
  logic              bus_valid_q;
  logic              bus_op_q;
  logic [15:0]       bus_addr_q;
  logic [15:0]       bus_wr_data_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_data_q;
  logic [15:0]       rsp_addr_q;
  logic              rsp_err_q;
  logic [15:0]       wr_cnt_q;
  logic [15:0]       rd_cnt_q;
  logic [15:0]       iss_addr_q;
  logic              iss_oor_q;

  logic              push;
  logic              pop;
  logic              head_op;
  logic [15:0]       head_addr;
  logic [15:0]       head_wdata;
  logic              head_oor;

  assign cmd_ready = (count_q != c_full_cnt);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign {head_op, head_addr, head_wdata} = fifo_mem_q[rd_ptr_q];
  // Range test in 17 bits so a map ending at 16'hFFFF cannot wrap.
  assign head_oor  = ({1'b0, head_addr} < {1'b0, BASE_ADDR}) ||
                     ({1'b0, head_addr} > c_last_addr);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      bus_valid_q   <= 1'b0;
      bus_op_q      <= 1'b0;
      bus_addr_q    <= 16'h0;
      bus_wr_data_q <= 16'h0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 16'h0;
      rsp_addr_q    <= 16'h0;
      rsp_err_q     <= 1'b0;
      wr_cnt_q      <= 16'h0;
      rd_cnt_q      <= 16'h0;
      iss_addr_q    <= 16'h0;
      iss_oor_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
      case ({push, pop})
        2'b10:   count_q <= count_q + c_cnt_one;
        2'b01:   count_q <= count_q - c_cnt_one;
        default: count_q <= count_q;
      endcase

      case (state_q)
        IDLE: begin
          if (pop) begin
            bus_valid_q   <= 1'b1;
            bus_op_q      <= head_op;
            bus_addr_q    <= head_addr;
            bus_wr_data_q <= head_op ? head_wdata : 16'h0;
            iss_addr_q    <= head_addr;
            iss_oor_q     <= head_oor;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          bus_valid_q   <= 1'b0;
          bus_op_q      <= 1'b0;
          bus_addr_q    <= 16'h0;
          bus_wr_data_q <= 16'h0;
          if (bus_op_q) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
            state_q  <= IDLE;
          end else begin
            state_q  <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Memory registers read data one cycle after the strobe.
          rsp_data_q  <= bus_rd_data;
          rsp_addr_q  <= iss_addr_q;
          rsp_err_q   <= iss_oor_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rd_cnt_q    <= rd_cnt_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_valid   = bus_valid_q;
  assign bus_op      = bus_op_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_err     = rsp_err_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
  assign busy        = (count_q != '0) || (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================================
// tb_mem_bus_master : directed, table-driven bench for mem_bus_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        bus_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_err;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic        busy;

  mem_bus_master #(.FIFO_DEPTH(4), .BASE_ADDR(16'h0010), .NUM_WORDS(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: 10 words at 0x10..0x19, out-of-range reads return 0.
  logic [15:0] mem [10];
  int          pulses = 0;
  int          cyc = 0;
  int          rsp_seen = 0;
  int          pulse_cyc [$];
  logic [15:0] wr_addrs [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
    if (bus_valid) begin
      pulses <= pulses + 1;
      pulse_cyc.push_back(cyc);
      if (bus_op) wr_addrs.push_back(bus_addr);
      if (bus_op && bus_addr >= 16'h0010 && bus_addr <= 16'h0019)
        mem[int'(bus_addr - 16'h0010)] <= bus_wr_data;
      if (!bus_op)
        bus_rd_data <= (bus_addr >= 16'h0010 && bus_addr <= 16'h0019) ?
                       mem[int'(bus_addr - 16'h0010)] : 16'h0;
    end
  end

  int ntests = 0;
  int nfail  = 0;
  int exp_wr = 0;
  int exp_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic op, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      ntests++; nfail++;
      $display("FAIL push_timeout: cmd_ready=0 for %0d cycles, required 1", n);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_valid) && n < 60) begin @(negedge clk); n++; end
    check("idle_reached", {31'd0, busy || rsp_valid}, 32'd0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    check("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
  endtask

  typedef struct {
    logic        op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int p0;
    int ok;
    logic [15:0] exp_q [$];

    vecs[0]  = '{1'b1, 16'h0010, 16'hA5A5, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hA5A5, 1'b0};
    vecs[2]  = '{1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1};
    vecs[3]  = '{1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1};
    vecs[5]  = '{1'b1, 16'h0019, 16'hBEEF, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 16'h0019, 16'h0000, 16'hBEEF, 1'b0};
    vecs[7]  = '{1'b0, 16'h000F, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 16'h001A, 16'h0000, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'h5555, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 16'h0;
    cmd_wdata = 16'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_counts", {wr_cnt, rd_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      p0 = pulses;
      push_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].op) begin
        wait_idle();
        exp_wr++;
      end else begin
        wait_rsp();
        check("vec_rsp_data", {16'd0, rsp_data}, {16'd0, vecs[i].exp_data});
        check("vec_rsp_addr", {16'd0, rsp_addr}, {16'd0, vecs[i].addr});
        check("vec_rsp_err", {31'd0, rsp_err}, {31'd0, vecs[i].exp_err});
        @(negedge clk);
        exp_rd++;
        wait_idle();
      end
      check("vec_bus_pulses", pulses - p0, 32'd1);
      check("vec_wr_cnt", {16'd0, wr_cnt}, exp_wr);
      check("vec_rd_cnt", {16'd0, rd_cnt}, exp_rd);
    end

    // Read latency from an idle, empty block.
    push_cmd(1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    check("lat_bus_valid", {31'd0, bus_valid}, 32'd1);
    check("lat_bus_addr", {15'd0, bus_op, bus_addr}, 32'h0000_0010);
    @(negedge clk);
    check("lat_bus_drop", {31'd0, bus_valid}, 32'd0);
    @(negedge clk);
    check("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    exp_rd++;
    wait_idle();

    // Back-to-back writes: one bus pulse every 2 cycles.
    pulse_cyc.delete();
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 16'h0011 + 16'(i), 16'h2000 + 16'(i));
    wait_idle();
    exp_wr += 4;
    check("thr_pulse_count", pulse_cyc.size(), 32'd4);
    if (pulse_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("thr_spacing", pulse_cyc[i] - pulse_cyc[i-1], 32'd2);

    // FIFO fills while the FSM is stalled in RESP.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 16'h0010, 16'h0);
    wait_rsp();
    wr_addrs.delete();
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 16'h0015 + 16'(i), 16'h3000 + 16'(i));
    check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    p0 = pulses;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 16'h0019; cmd_wdata = 16'h7777;
    repeat (3) @(negedge clk);
    check("full_still_blocked", {31'd0, cmd_ready}, 32'd0);
    check("full_no_pulse", pulses - p0, 32'd0);
    check("full_rsp_data", {16'd0, rsp_data}, 32'h0000_A5A5);
    rsp_ready = 1'b1;
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      if (cmd_ready) ok = 1; else @(negedge clk);
    end
    check("fifth_accepted", ok, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_rd++;
    wait_idle();
    exp_wr += 5;
    exp_q = '{16'h0015, 16'h0016, 16'h0017, 16'h0018, 16'h0019};
    check("order_count", wr_addrs.size(), 32'd5);
    if (wr_addrs.size() == 5)
      for (int i = 0; i < 5; i++) check("order_addr", {16'd0, wr_addrs[i]}, {16'd0, exp_q[i]});
    check("stall_wr_cnt", {16'd0, wr_cnt}, exp_wr);
    check("stall_rd_cnt", {16'd0, rd_cnt}, exp_rd);

    // Response held for 10 cycles with rsp_ready low.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 16'h0019, 16'h0);
    wait_rsp();
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp", {15'd0, rsp_valid, rsp_data}, 32'h0001_7777);
    end
    check("hold_no_pulse", pulses - p0, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_rd++;
    wait_idle();
    check("hold_rd_cnt", {16'd0, rd_cnt}, exp_rd);

    // Reset in the ISSUE cycle of a read with three commands queued.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 16'h0010, 16'h0);
    wait_rsp();
    push_cmd(1'b0, 16'h0011, 16'h0);
    push_cmd(1'b1, 16'h0012, 16'hDEAD);
    push_cmd(1'b1, 16'h0013, 16'hDEAD);
    push_cmd(1'b0, 16'h0014, 16'h0);
    rsp_ready = 1'b1;
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(negedge clk);
      if (bus_valid && !bus_op && bus_addr == 16'h0011) ok = 1;
    end
    check("rstmid_issue_seen", ok, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_bus", {bus_valid, bus_op, bus_addr, bus_wr_data[13:0]}, 32'd0);
    check("rstmid_bus_wdata", {16'd0, bus_wr_data}, 32'd0);
    check("rstmid_rsp", {rsp_valid, rsp_err, rsp_addr, rsp_data[13:0]}, 32'd0);
    check("rstmid_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rstmid_counts", {wr_cnt, rd_cnt}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    p0 = pulses;
    ok = rsp_seen;
    repeat (10) @(negedge clk);
    check("rstmid_no_pulse", pulses - p0, 32'd0);
    check("rstmid_no_rsp", rsp_seen - ok, 32'd0);
    exp_wr = 0;
    exp_rd = 0;

    // Fill and read back the whole mapped window.
    for (int i = 0; i < 10; i++) push_cmd(1'b1, 16'h0010 + 16'(i), 16'h1000 + 16'(i));
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      push_cmd(1'b0, 16'h0010 + 16'(i), 16'h0);
      wait_rsp();
      check("sweep_data", {15'd0, rsp_err, rsp_data}, {16'd0, 16'h1000 + 16'(i)});
      @(negedge clk);
    end
    wait_idle();
    check("sweep_wr_cnt", {16'd0, wr_cnt}, 32'd10);
    check("sweep_rd_cnt", {16'd0, rd_cnt}, 32'd10);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
